systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Parametrised operand-feed scheduler for an ROWS x COLS systolic array.
- Generates the diagonally skewed SRAM read enables and addresses for the A lanes (one per row) and the B lanes (one per column) over a runtime-programmable reduction depth k_len.
- Supports global stall, abort, a parametrised drain phase for PE pipeline latency, and a start/busy/done handshake.
- Sits between the tile controller and the per-lane operand SRAMs.

Parameters:
- ROWS, 8, number of A lanes (array rows)
- COLS, 8, number of B lanes (array columns)
- ADDR_W, 10, SRAM address width per lane
- K_W, 10, width of k_len (max depth 2^K_W-1)
- DRAIN, 4, cycles held in DRAIN after the last feed step (PE/accumulator latency); must be >= 1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  begin a tile; sampled only in IDLE
- abort  in  1  cancel the current tile; highest priority after reset
- k_len  in  K_W  reduction depth; sampled with start
- base_a  in  ADDR_W  A base address; sampled with start
- base_b  in  ADDR_W  B base address; sampled with start
- stall  in  1  freeze flow (downstream/float unit not ready)
- re_a  out  ROWS  per-row SRAM read enable
- addr_a  out  ROWS*ADDR_W  per-row read address, packed, lane i at [i*ADDR_W +: ADDR_W]
- re_b  out  COLS  per-column SRAM read enable
- addr_b  out  COLS*ADDR_W  per-column read address, packed likewise
- busy  out  1  high in FEED or DRAIN
- done  out  1  one-cycle pulse on tile completion

Behaviour:
- Reset: async on rst=0. State IDLE, step=0, drain_cnt=0, latched k/base=0. All outputs 0.
- State machine: IDLE, FEED, DRAIN, DONE.
- Capture: in IDLE with start=1, latch k_len, base_a and base_b, clear step, and move to FEED. If k_len==0, go to DONE instead and issue no reads.
- Feed length: TOTAL = k_len + max(ROWS,COLS) - 1 feed steps. The step counter is wide enough that TOTAL never overflows: K_W + clog2(max(ROWS,COLS)) + 1 bits.
- Advance: in FEED, ahead = !stall. When ahead=1, step increments. When step==TOTAL-1 and ahead=1, go to DRAIN with drain_cnt=0.
- Lane activity:
  - re_a[i] = (state==FEED) && ahead && (i <= step < i + k_len).
  - re_b[j] follows the same rule with j.
- Addresses:
  - addr_a[i] = base_a + (step - i) mod 2^ADDR_W when re_a[i]=1, else 0.
  - addr_b[j] is formed the same way from base_b.
  - Enables and addresses are combinational from registered state, so the first read (lane 0, addr base) appears in the first FEED cycle, i.e. the cycle after start is accepted.
- Stall: all re_* = 0 and step holds. Flow either advances or holds; no partial advance.
- DRAIN: drain_cnt increments only when stall=0. When drain_cnt==DRAIN-1 and stall=0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE and IDLE.
- Ignored inputs: start in FEED, DRAIN or DONE is ignored.
- abort=1 in any state:
  - next state IDLE, with no done pulse;
  - re_* are forced 0 in the same cycle;
  - abort takes priority over start.
- Address wrap: addresses wrap modulo 2^ADDR_W with no error flag.
- Simultaneous events:
  - stall and abort together: abort wins.
  - stall=1 on the final FEED step: the transition to DRAIN is delayed.

Test Plan:
- ROWS=COLS=4, k_len=3, base_a=0, base_b=16, no stall:
  - re_a[0] is high for the first 3 FEED cycles with addr 0,1,2.
  - re_a[3] is high in FEED cycles 3..5 with addr 0,1,2.
  - addr_b[2] = 16,17,18 in cycles 2..4.
  - FEED lasts 6 cycles, then DRAIN 4, and done pulses on the 11th cycle after start was accepted.
- Same config, stall=1 in FEED cycles 2 and 3:
  - all re low in those cycles and step frozen at 2;
  - the address sequence resumes unchanged;
  - done arrives 2 cycles later than in the unstalled run.
- start with k_len=0 → done pulses the next cycle, no re_* ever high, busy never high.
- base_a=1022 (ADDR_W=10), k_len=4 → lane 0 addresses 1022,1023,0,1.
- abort asserted in FEED step 3 → next cycle IDLE, no done, re all 0. A new start is accepted immediately.
- ROWS=2, COLS=6, k_len=2:
  - TOTAL=7 feed steps;
  - re_a lanes idle after step 2 while re_b[5] is active at steps 5..6.
  - Reset asserted mid-DRAIN → all outputs 0 immediately.

Source files
------------

// File: rtl/systolic_feeder.sv
// Operand-feed scheduler for a ROWS x COLS systolic array. It produces diagonally skewed
// SRAM reads, so lane i reads base+0 .. base+k_len-1 on feed steps i .. i+k_len-1.
module systolic_feeder #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int ADDR_W = 10,
    parameter int K_W    = 10,
    parameter int DRAIN  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [K_W-1:0]         k_len,
    input  logic [ADDR_W-1:0]      base_a,
    input  logic [ADDR_W-1:0]      base_b,
    input  logic                   stall,
    output logic [ROWS-1:0]        re_a,
    output logic [ROWS*ADDR_W-1:0] addr_a,
    output logic [COLS-1:0]        re_b,
    output logic [COLS*ADDR_W-1:0] addr_b,
    output logic                   busy,
    output logic                   done
);

    localparam int MAX_RC = (ROWS > COLS) ? ROWS : COLS;
    localparam int STEP_W = K_W + $clog2(MAX_RC) + 1;
    localparam int DCNT_W = $clog2(DRAIN) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] total;
    logic [DCNT_W-1:0] drain_cnt;
    logic [K_W-1:0]    k_q;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic              ahead;

    // The last lane starts MAX_RC-1 steps late, so the feed stretches by that skew.
    assign total = STEP_W'(k_q) + STEP_W'(MAX_RC - 1);
    assign ahead = (state == S_FEED) && !stall && !abort;
    assign busy  = (state == S_FEED) || (state == S_DRAIN);
    assign done  = (state == S_DONE) && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            step      <= '0;
            drain_cnt <= '0;
            k_q       <= '0;
            base_a_q  <= '0;
            base_b_q  <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            step      <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_q       <= k_len;
                        base_a_q  <= base_a;
                        base_b_q  <= base_b;
                        step      <= '0;
                        drain_cnt <= '0;
                        state     <= (k_len == '0) ? S_DONE : S_FEED;
                    end
                end
                S_FEED: begin
                    if (!stall) begin
                        step <= step + 1'b1;
                        if (step == total - 1'b1) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        if (drain_cnt == DCNT_W'(DRAIN - 1)) begin
                            state <= S_DONE;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // A lane is live while the wavefront (step) lies inside its k_len-wide window.
    always_comb begin
        re_a   = '0;
        addr_a = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (ahead && (step >= STEP_W'(i)) && (step < STEP_W'(i) + STEP_W'(k_q))) begin
                re_a[i]                    = 1'b1;
                addr_a[i*ADDR_W +: ADDR_W] = base_a_q + ADDR_W'(step - STEP_W'(i));
            end
        end
    end

    always_comb begin
        re_b   = '0;
        addr_b = '0;
        for (int j = 0; j < COLS; j++) begin
            if (ahead && (step >= STEP_W'(j)) && (step < STEP_W'(j) + STEP_W'(k_q))) begin
                re_b[j]                    = 1'b1;
                addr_b[j*ADDR_W +: ADDR_W] = base_b_q + ADDR_W'(step - STEP_W'(j));
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomised scoreboard bench for systolic_feeder. Each tile's expected reads, busy window
// and done pulse are derived from the stall pattern and then checked by a separate monitor.
module tb_systolic_feeder;

    localparam int ROWS   = 4;
    localparam int COLS   = 6;
    localparam int ADDR_W = 10;
    localparam int K_W    = 10;
    localparam int DRAIN  = 4;
    localparam int MAX_RC = (ROWS > COLS) ? ROWS : COLS;
    localparam int AMOD   = 1 << ADDR_W;
    localparam int LANES  = ROWS + COLS;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic                   stall = 1'b0;
    logic [K_W-1:0]         k_len = '0;
    logic [ADDR_W-1:0]      base_a = '0;
    logic [ADDR_W-1:0]      base_b = '0;
    logic [ROWS-1:0]        re_a;
    logic [ROWS*ADDR_W-1:0] addr_a;
    logic [COLS-1:0]        re_b;
    logic [COLS*ADDR_W-1:0] addr_b;
    logic                   busy;
    logic                   done;

    typedef struct {
        int cyc;
        int addr;
    } rd_t;

    rd_t q[LANES][$];
    int  qdone[$];
    bit  exp_busy[int];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    systolic_feeder #(
        .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .K_W(K_W), .DRAIN(DRAIN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .k_len(k_len), .base_a(base_a), .base_b(base_b), .stall(stall),
        .re_a(re_a), .addr_a(addr_a), .re_b(re_b), .addr_b(addr_b),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Monitor: every cycle, consume whatever the scoreboard expects for this cycle.
    always @(negedge clk) begin : monitor
        rd_t  e;
        bit   exp_re;
        int   exp_addr;
        logic act_re;
        int   act_addr;
        bit   exp_done;
        for (int l = 0; l < LANES; l++) begin
            if (l < ROWS) begin
                act_re   = re_a[l];
                act_addr = int'(addr_a[l*ADDR_W +: ADDR_W]);
            end else begin
                act_re   = re_b[l-ROWS];
                act_addr = int'(addr_b[(l-ROWS)*ADDR_W +: ADDR_W]);
            end
            exp_re   = (q[l].size() > 0) && (q[l][0].cyc == cyc);
            exp_addr = 0;
            if (exp_re) begin
                e        = q[l].pop_front();
                exp_addr = e.addr;
            end
            checkOutput($sformatf("re lane %0d", l), 32'(act_re), 32'(exp_re));
            checkOutput($sformatf("addr lane %0d", l), 32'(act_addr), 32'(exp_addr));
        end
        exp_done = (qdone.size() > 0) && (qdone[0] == cyc);
        if (exp_done) void'(qdone.pop_front());
        checkOutput("done", 32'(done), 32'(exp_done));
        checkOutput("busy", 32'(busy), exp_busy.exists(cyc) ? 32'd1 : 32'd0);
    end

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            start = 1'b0;
            abort = 1'($urandom_range(0, 1));
            stall = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    // mode: 0 = runs to done, 1 = abort at a random busy cycle, 2 = reset during drain
    task automatic applyStimulus(input int k, input int ba, input int bb, input int sp, input int mode);
        int n0, total, r, fed, dr, done_r, cut, end_r, last_feed_r;
        bit st;
        int adv[$];
        bit pat[$];
        n0    = cyc;
        total = (k == 0) ? 0 : k + MAX_RC - 1;
        pat.push_back(1'b0);
        r   = 0;
        fed = 0;
        while (fed < total) begin
            r++;
            st = ($urandom_range(0, 99) < sp);
            pat.push_back(st);
            if (!st) begin
                adv.push_back(n0 + r);
                fed++;
            end
        end
        if (k != 0) begin
            dr = 0;
            while (dr < DRAIN) begin
                r++;
                st = ($urandom_range(0, 99) < sp);
                pat.push_back(st);
                if (!st) dr++;
            end
        end
        done_r = r + 1;
        pat.push_back(1'($urandom_range(0, 1)));
        last_feed_r = (adv.size() > 0) ? adv[adv.size()-1] - n0 : 0;
        cut = 0;
        if (mode == 1 && k != 0) cut = $urandom_range(1, done_r - 1);
        if (mode == 2 && k != 0) cut = $urandom_range(last_feed_r + 1, done_r - 1);
        end_r = (cut != 0) ? cut : done_r;

        // Lane n reads base+t on the (n+t)-th advancing feed cycle.
        for (int l = 0; l < LANES; l++) begin
            int base = (l < ROWS) ? ba : bb;
            int lane = (l < ROWS) ? l : l - ROWS;
            for (int t = 0; t < k; t++) begin
                int c = adv[lane + t];
                if (cut == 0 || c < n0 + cut) q[l].push_back(rd_t'{cyc: c, addr: (base + t) % AMOD});
            end
        end
        for (int b = 1; b < end_r; b++) exp_busy[n0 + b] = 1'b1;
        if (mode == 1 && cut != 0) exp_busy[n0 + cut] = 1'b1;
        if (cut == 0) qdone.push_back(n0 + done_r);

        for (int rr = 0; rr <= end_r; rr++) begin
            start  = (rr == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            k_len  = (rr == 0) ? K_W'(k) : K_W'($urandom);
            base_a = (rr == 0) ? ADDR_W'(ba) : ADDR_W'($urandom);
            base_b = (rr == 0) ? ADDR_W'(bb) : ADDR_W'($urandom);
            stall  = pat[rr];
            abort  = (mode == 1) && (cut != 0) && (rr == cut);
            rst    = !((mode == 2) && (cut != 0) && (rr == cut));
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
        rst   = 1'b1;
    endtask

    initial begin
        int k, mode;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        applyStimulus(3, 0, 16, 0, 0);
        applyStimulus(3, 0, 16, 30, 0);
        applyStimulus(0, 5, 5, 0, 0);
        applyStimulus(4, 1022, 1020, 0, 0);
        applyStimulus(5, 100, 200, 10, 1);
        applyStimulus(3, 7, 9, 0, 0);
        applyStimulus(2, 40, 50, 20, 2);
        idle(2);
        repeat (40) begin
            k    = $urandom_range(0, 24);
            mode = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 2)) : 0;
            applyStimulus(k, $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1),
                          $urandom_range(0, 40), mode);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        applyStimulus(1023, 1000, 3, 5, 0);
        idle(4);
        for (int l = 0; l < LANES; l++) checkOutput($sformatf("pending reads lane %0d", l), 32'(q[l].size()), 32'd0);
        checkOutput("pending done", 32'(qdone.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
